// File: rtl/vp_cfg_ctrl.sv
// Frame-synchronous configuration controller for the video-process chain (clk_vpm domain).
// Optional register readback port enabled by defining VP_CFG_READBACK_EN.
module vp_cfg_ctrl #(
  parameter int unsigned H_DISP          = 1280,
  parameter int unsigned V_DISP          = 720,
  parameter int unsigned X_RES_WIDTH     = 11,
  parameter int unsigned Y_RES_WIDTH     = 11,
  parameter int unsigned SCALE_FRAC_BITS = 14,
  parameter int unsigned SCALE_BITS      = 18
) (
  input  logic                   clk_vpm,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [2:0]             cfg_addr,
  input  logic [11:0]            cfg_wdata,
  input  logic                   vs_i,
`ifdef VP_CFG_READBACK_EN
  input  logic                   cfg_re,
  output logic [11:0]            cfg_rdata,
`endif
  output logic                   cfg_busy,
  output logic                   cfg_err,
  output logic                   cfg_valid,
  output logic [11:0]            start_x,
  output logic [11:0]            end_x,
  output logic [11:0]            start_y,
  output logic [11:0]            end_y,
  output logic [X_RES_WIDTH-1:0] input_x_res,
  output logic [Y_RES_WIDTH-1:0] input_y_res,
  output logic [X_RES_WIDTH-1:0] output_x_res,
  output logic [Y_RES_WIDTH-1:0] output_y_res,
  output logic [SCALE_BITS-1:0]  x_scale,
  output logic [SCALE_BITS-1:0]  y_scale,
  output logic                   nearest
);

  localparam int unsigned CW      = 12;
  localparam int unsigned DIV_W   = 32;
  localparam int unsigned CNT_W   = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_W - 1);
  localparam logic [CW-1:0] H_MAX = CW'(H_DISP);
  localparam logic [CW-1:0] V_MAX = CW'(V_DISP);
  localparam logic [SCALE_BITS-1:0] SCALE_ONE = SCALE_BITS'(1 << SCALE_FRAC_BITS);

  typedef enum logic [2:0] {IDLE, CHECK, DIV_X, DIV_Y, READY, APPLY} state_t;

  state_t state, state_nxt;

  // Host-writable shadow set and the snapshot taken when a commit passes validation
  logic [CW-1:0]          sh_start_x, sh_end_x, sh_start_y, sh_end_y;
  logic [X_RES_WIDTH-1:0] sh_out_x;
  logic [Y_RES_WIDTH-1:0] sh_out_y;
  logic                   sh_nearest;
  logic [CW-1:0]          snap_start_x, snap_end_x, snap_start_y, snap_end_y;
  logic [X_RES_WIDTH-1:0] snap_out_x;
  logic [Y_RES_WIDTH-1:0] snap_out_y;
  logic                   snap_nearest;

  logic [DIV_W-1:0]       quo, rem, div_d;
  logic [CNT_W-1:0]       div_cnt;
  logic [SCALE_BITS-1:0]  x_q, y_q;
  logic                   vs_d;

  logic                   commit, vs_rise, cfg_ok, take;
  logic [CW-1:0]          dx_sh, dy_snap;
  logic [DIV_W:0]         rem_sh;
  logic [DIV_W-1:0]       quo_nxt, rem_nxt;
  logic [SCALE_BITS-1:0]  q_sat;

  assign commit  = cfg_we && (cfg_addr == 3'd7);
  assign vs_rise = vs_i && !vs_d;
  assign cfg_ok  = (sh_end_x > sh_start_x) && (sh_end_x <= H_MAX) &&
                   (sh_end_y > sh_start_y) && (sh_end_y <= V_MAX);
  assign dx_sh   = sh_end_x - sh_start_x;
  assign dy_snap = snap_end_y - snap_start_y;

  // One restoring-divide step per cycle; quotient bits shift in from the LSB
  assign rem_sh  = {rem, quo[DIV_W-1]};
  assign take    = rem_sh >= {1'b0, div_d};
  assign rem_nxt = take ? DIV_W'(rem_sh - {1'b0, div_d}) : DIV_W'(rem_sh);
  assign quo_nxt = {quo[DIV_W-2:0], take};
  assign q_sat   = (|quo_nxt[DIV_W-1:SCALE_BITS]) ? {SCALE_BITS{1'b1}}
                                                  : quo_nxt[SCALE_BITS-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (commit) state_nxt = CHECK;
      CHECK:   if (commit) state_nxt = CHECK;
               else        state_nxt = cfg_ok ? DIV_X : IDLE;
      DIV_X:   if (commit) state_nxt = CHECK;
               else if (div_cnt == CNT_LAST) state_nxt = DIV_Y;
      DIV_Y:   if (commit) state_nxt = CHECK;
               else if (div_cnt == CNT_LAST) state_nxt = READY;
      READY:   if (commit) state_nxt = CHECK;
               else if (vs_rise) state_nxt = APPLY;
      APPLY:   state_nxt = commit ? CHECK : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shadow registers accept writes in every state
  always_ff @(posedge clk_vpm or negedge rst_n) begin
    if (!rst_n) begin
      sh_start_x <= '0;
      sh_start_y <= '0;
      sh_end_x   <= H_MAX;
      sh_end_y   <= V_MAX;
      sh_out_x   <= X_RES_WIDTH'(H_DISP - 1);
      sh_out_y   <= Y_RES_WIDTH'(V_DISP - 1);
      sh_nearest <= 1'b1;
    end else if (cfg_we) begin
      case (cfg_addr)
        3'd0:    sh_start_x <= cfg_wdata;
        3'd1:    sh_start_y <= cfg_wdata;
        3'd2:    sh_end_x   <= cfg_wdata;
        3'd3:    sh_end_y   <= cfg_wdata;
        3'd4:    sh_out_x   <= cfg_wdata[X_RES_WIDTH-1:0];
        3'd5:    sh_out_y   <= cfg_wdata[Y_RES_WIDTH-1:0];
        3'd6:    sh_nearest <= cfg_wdata[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_vpm or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cfg_busy     <= 1'b0;
      cfg_err      <= 1'b0;
      cfg_valid    <= 1'b0;
      vs_d         <= 1'b0;
      snap_start_x <= '0;
      snap_start_y <= '0;
      snap_end_x   <= '0;
      snap_end_y   <= '0;
      snap_out_x   <= '0;
      snap_out_y   <= '0;
      snap_nearest <= 1'b0;
      quo          <= '0;
      rem          <= '0;
      div_d        <= '0;
      div_cnt      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      start_x      <= '0;
      start_y      <= '0;
      end_x        <= H_MAX;
      end_y        <= V_MAX;
      input_x_res  <= X_RES_WIDTH'(H_DISP - 1);
      input_y_res  <= Y_RES_WIDTH'(V_DISP - 1);
      output_x_res <= X_RES_WIDTH'(H_DISP - 1);
      output_y_res <= Y_RES_WIDTH'(V_DISP - 1);
      x_scale      <= SCALE_ONE;
      y_scale      <= SCALE_ONE;
      nearest      <= 1'b1;
    end else begin
      state     <= state_nxt;
      cfg_busy  <= (state_nxt != IDLE);
      cfg_valid <= 1'b0;
      vs_d      <= vs_i;
      case (state)
        CHECK: if (!commit) begin
          if (!cfg_ok) begin
            cfg_err <= 1'b1;
          end else begin
            cfg_err      <= 1'b0;
            snap_start_x <= sh_start_x;
            snap_start_y <= sh_start_y;
            snap_end_x   <= sh_end_x;
            snap_end_y   <= sh_end_y;
            snap_out_x   <= sh_out_x;
            snap_out_y   <= sh_out_y;
            snap_nearest <= sh_nearest;
            quo          <= DIV_W'(dx_sh) << SCALE_FRAC_BITS;
            rem          <= '0;
            div_d        <= DIV_W'(sh_out_x) + DIV_W'(1);
            div_cnt      <= '0;
          end
        end
        DIV_X: if (!commit) begin
          quo     <= quo_nxt;
          rem     <= rem_nxt;
          div_cnt <= div_cnt + CNT_W'(1);
          if (div_cnt == CNT_LAST) begin
            x_q   <= q_sat;
            quo   <= DIV_W'(dy_snap) << SCALE_FRAC_BITS;
            rem   <= '0;
            div_d <= DIV_W'(snap_out_y) + DIV_W'(1);
          end
        end
        DIV_Y: if (!commit) begin
          quo     <= quo_nxt;
          rem     <= rem_nxt;
          div_cnt <= div_cnt + CNT_W'(1);
          if (div_cnt == CNT_LAST) y_q <= q_sat;
        end
        // Whole active set loads on the same edge that enters APPLY
        READY: if (!commit && vs_rise) begin
          start_x      <= snap_start_x;
          start_y      <= snap_start_y;
          end_x        <= snap_end_x;
          end_y        <= snap_end_y;
          input_x_res  <= X_RES_WIDTH'(snap_end_x - snap_start_x - CW'(1));
          input_y_res  <= Y_RES_WIDTH'(snap_end_y - snap_start_y - CW'(1));
          output_x_res <= snap_out_x;
          output_y_res <= snap_out_y;
          x_scale      <= x_q;
          y_scale      <= y_q;
          nearest      <= snap_nearest;
          cfg_valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef VP_CFG_READBACK_EN
  always_ff @(posedge clk_vpm or negedge rst_n) begin
    if (!rst_n) begin
      cfg_rdata <= '0;
    end else if (cfg_re) begin
      case (cfg_addr)
        3'd0:    cfg_rdata <= start_x;
        3'd1:    cfg_rdata <= start_y;
        3'd2:    cfg_rdata <= end_x;
        3'd3:    cfg_rdata <= end_y;
        3'd4:    cfg_rdata <= CW'(output_x_res);
        3'd5:    cfg_rdata <= CW'(output_y_res);
        3'd6:    cfg_rdata <= {11'b0, nearest};
        default: cfg_rdata <= {9'b0, cfg_err, cfg_busy, nearest};
      endcase
    end
  end
`endif

endmodule
